// File: rtl/dsp_v8_pkg.sv
// Shared types and sizing helpers for the V8 vector DSP datapath.
// Default lane geometry and the serializer state encoding live here.
package dsp_v8_pkg;

    localparam int unsigned DEF_REG_WIDTH = 16;
    localparam int unsigned DEF_VECTOR    = 8;

    // Lane index width; a single-lane build still carries a 1-bit index.
    function automatic int unsigned lane_idx_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } ser_state_t;

endpackage

// File: rtl/vector_lane_serializer_v8.sv
// Serializes one captured (a, b) vector into per-lane beats on a valid/ready stream.
// A new vector may be captured on the last-beat transfer, so back-to-back vectors have no bubble.
module vector_lane_serializer_v8
    import dsp_v8_pkg::*;
#(
    parameter int unsigned REG_WIDTH = DEF_REG_WIDTH,
    parameter int unsigned VECTOR    = DEF_VECTOR,
    localparam int unsigned IDX_W    = lane_idx_w(VECTOR)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [REG_WIDTH-1:0] in_a [VECTOR-1:0],
    input  logic [REG_WIDTH-1:0] in_b [VECTOR-1:0],
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [REG_WIDTH-1:0] out_a,
    output logic [REG_WIDTH-1:0] out_b,
    output logic [IDX_W-1:0]     out_lane,
    output logic                 out_last
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VECTOR - 1);

    ser_state_t           state;
    logic [IDX_W-1:0]     idx;
    logic [REG_WIDTH-1:0] hold_a [VECTOR-1:0];
    logic [REG_WIDTH-1:0] hold_b [VECTOR-1:0];

    logic is_last;
    logic accept;
    logic capture;

    assign is_last = (idx == LAST_IDX);
    assign accept  = (state == IDLE) || (out_ready && is_last);
    assign capture = in_valid && accept;

    // Gated by rst so upstream never sees a capture opportunity while in reset.
    assign in_ready  = !rst && accept;
    assign out_valid = (state == SEND);
    assign out_lane  = idx;
    assign out_last  = is_last;

    // Lane select; idx never exceeds VECTOR-1, so the default is unreachable.
    always_comb begin
        out_a = '0;
        out_b = '0;
        for (int i = 0; i < int'(VECTOR); i++) begin
            if (idx == IDX_W'(i)) begin
                out_a = hold_a[i];
                out_b = hold_b[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
            for (int i = 0; i < int'(VECTOR); i++) begin
                hold_a[i] <= '0;
                hold_b[i] <= '0;
            end
        end else if (capture) begin
            // Covers both the idle capture and the last-beat reload.
            state <= SEND;
            idx   <= '0;
            for (int i = 0; i < int'(VECTOR); i++) begin
                hold_a[i] <= in_a[i];
                hold_b[i] <= in_b[i];
            end
        end else if (state == SEND && out_ready) begin
            if (is_last) begin
                state <= IDLE;
                idx   <= '0;
            end else begin
                idx <= idx + IDX_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_vector_lane_serializer_v8.sv
// Scoreboard bench for vector_lane_serializer_v8: an 8-lane instance and a 1-lane instance.
module tb_vector_lane_serializer_v8;

    localparam int unsigned W = 16;
    localparam int unsigned V = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          in_valid, in_ready, out_valid, out_ready, out_last;
    logic [W-1:0]  in_a [V-1:0];
    logic [W-1:0]  in_b [V-1:0];
    logic [W-1:0]  out_a, out_b;
    logic [2:0]    out_lane;

    logic          in_valid1, in_ready1, out_valid1, out_ready1, out_last1;
    logic [W-1:0]  in_a1 [0:0];
    logic [W-1:0]  in_b1 [0:0];
    logic [W-1:0]  out_a1, out_b1;
    logic [0:0]    out_lane1;

    vector_lane_serializer_v8 #(.REG_WIDTH(W), .VECTOR(V)) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a), .out_b(out_b),
        .out_lane(out_lane), .out_last(out_last)
    );

    vector_lane_serializer_v8 #(.REG_WIDTH(W), .VECTOR(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid1), .in_ready(in_ready1), .in_a(in_a1), .in_b(in_b1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_a(out_a1), .out_b(out_b1),
        .out_lane(out_lane1), .out_last(out_last1)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        int           lane;
        bit           last;
    } beat_t;

    beat_t q  [$];
    beat_t q1 [$];
    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives a vector a=ba+i, b=bb+i and queues its expected lane beats.
    task automatic load_vec(input int ba, input int bb);
        for (int i = 0; i < int'(V); i++) begin
            in_a[i] = W'(ba + i);
            in_b[i] = W'(bb + i);
            q.push_back('{a: W'(ba + i), b: W'(bb + i), lane: i, last: (i == int'(V) - 1)});
        end
    endtask

    task automatic push1(input int a, input int b);
        in_a1[0] = W'(a);
        in_b1[0] = W'(b);
        q1.push_back('{a: W'(a), b: W'(b), lane: 0, last: 1'b1});
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((q.size() != 0 || out_valid || q1.size() != 0 || out_valid1) && n < budget) begin
            step();
            n++;
        end
        chk("drain_pending", 32'(q.size() + q1.size()), 32'd0);
        chk("drain_valid", 32'({out_valid, out_valid1}), 32'd0);
    endtask

    // Monitor: every accepted beat must match the head of its scoreboard queue.
    always @(negedge clk) begin
        beat_t e;
        if (!rst && out_valid && out_ready) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_beat actual lane=%0d a=%0h required=no beat", out_lane, out_a);
            end else begin
                e = q.pop_front();
                chk("out_a", 32'(out_a), 32'(e.a));
                chk("out_b", 32'(out_b), 32'(e.b));
                chk("out_lane", 32'(out_lane), 32'(e.lane));
                chk("out_last", 32'(out_last), 32'(e.last));
            end
        end
        if (!rst && out_valid1 && out_ready1) begin
            if (q1.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_beat1 actual a=%0h required=no beat", out_a1);
            end else begin
                e = q1.pop_front();
                chk("v1_out_a", 32'(out_a1), 32'(e.a));
                chk("v1_out_b", 32'(out_b1), 32'(e.b));
                chk("v1_out_lane", 32'(out_lane1), 32'(e.lane));
                chk("v1_out_last", 32'(out_last1), 32'(e.last));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        in_valid1  = 1'b0;
        out_ready1 = 1'b1;
        for (int i = 0; i < int'(V); i++) begin
            in_a[i] = '0;
            in_b[i] = '0;
        end
        in_a1[0] = '0;
        in_b1[0] = '0;

        // Reset state
        #12;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_a", 32'(out_a), 32'd0);
        chk("rst_out_b", 32'(out_b), 32'd0);
        chk("rst_out_lane", 32'(out_lane), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_v1_out_last", 32'(out_last1), 32'd1);
        chk("rst_v1_in_ready", 32'(in_ready1), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step();

        // Single vector, continuous out_ready
        load_vec(70, 80);
        in_valid = 1'b1;
        @(negedge clk);
        chk("t1_idle_in_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("t1_out_valid", 32'(out_valid), 32'd1);
            chk("t1_in_ready", 32'(in_ready), 32'(k == 7));
            step();
        end
        @(negedge clk);
        chk("t1_idle_after", 32'(out_valid), 32'd0);
        wait_drain(20);

        // Back-to-back vectors with in_valid held
        load_vec(10, 20);
        in_valid = 1'b1;
        step();
        load_vec(30, 40);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            chk("t2_out_valid", 32'(out_valid), 32'd1);
            chk("t2_in_ready", 32'(in_ready), 32'((k % 8) == 7));
            step();
            if (k == 7) in_valid = 1'b0;
        end
        @(negedge clk);
        chk("t2_idle_after", 32'(out_valid), 32'd0);
        wait_drain(20);

        // Backpressure held on lane 3
        load_vec(50, 60);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (3) step();
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t3_stall_valid", 32'(out_valid), 32'd1);
            chk("t3_stall_lane", 32'(out_lane), 32'd3);
            chk("t3_stall_a", 32'(out_a), 32'd53);
            chk("t3_stall_b", 32'(out_b), 32'd63);
            step();
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("t3_release_lane", 32'(out_lane), 32'd3);
        step();
        @(negedge clk);
        chk("t3_next_lane", 32'(out_lane), 32'd4);
        wait_drain(20);

        // Inputs changed after capture must not leak into the output
        load_vec(100, 110);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < int'(V); i++) begin
            in_a[i] = 16'hFFFF;
            in_b[i] = 16'hFFFF;
        end
        wait_drain(20);

        // Asynchronous reset during lane 5
        load_vec(200, 210);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (5) step();
        #2;
        chk("t5_pre_lane", 32'(out_lane), 32'd5);
        rst = 1'b1;
        q.delete();
        #1;
        chk("t5_rst_out_valid", 32'(out_valid), 32'd0);
        chk("t5_rst_in_ready", 32'(in_ready), 32'd0);
        step();
        @(negedge clk);
        chk("t5_rst_hold_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("t5_post_in_ready", 32'(in_ready), 32'd1);
        chk("t5_post_out_valid", 32'(out_valid), 32'd0);
        repeat (4) step();
        chk("t5_no_partial", 32'(out_valid), 32'd0);

        // Single-lane build at full rate
        push1(1, 11);
        in_valid1 = 1'b1;
        step();
        push1(2, 12);
        @(negedge clk);
        chk("t6_valid_b0", 32'(out_valid1), 32'd1);
        chk("t6_in_ready", 32'(in_ready1), 32'd1);
        step();
        push1(3, 13);
        @(negedge clk);
        chk("t6_valid_b1", 32'(out_valid1), 32'd1);
        step();
        in_valid1 = 1'b0;
        @(negedge clk);
        chk("t6_valid_b2", 32'(out_valid1), 32'd1);
        step();
        @(negedge clk);
        chk("t6_idle_after", 32'(out_valid1), 32'd0);
        wait_drain(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
